// File: rtl/ew_sensor_driver.sv
// Drives one complete E/W sensor passage on request, then waits for the
// detector's idle flag (or a timeout) before reporting completion.
module ew_sensor_driver #(
    parameter int HOLD    = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic dir,
    input  logic idle,
    output logic E,
    output logic W,
    output logic busy,
    output logic done,
    output logic err
);

    // Handshake: req is a level sampled only in IDLE; it is accepted on the
    // first IDLE edge where it is high. busy covers every other state, and
    // done (with err on timeout) pulses for the one DONE cycle.
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_PH1,
        S_PH2,
        S_PH3,
        S_RELEASE,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             dir_q, dir_nxt;
    logic             err_nxt;
    logic             e_nxt, w_nxt, busy_nxt, done_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dir_nxt   = dir_q;
        err_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    dir_nxt   = dir;
                    state_nxt = S_WAIT_RDY;
                    cnt_nxt   = '0;
                end
            end
            S_WAIT_RDY: begin
                if (idle) begin
                    state_nxt = S_PH1;
                    cnt_nxt   = '0;
                end else if (cnt == TO_LAST) begin
                    state_nxt = S_DONE;
                    err_nxt   = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_PH1, S_PH2, S_PH3: begin
                if (cnt == HOLD_LAST) begin
                    cnt_nxt = '0;
                    if (state == S_PH1)      state_nxt = S_PH2;
                    else if (state == S_PH2) state_nxt = S_PH3;
                    else                     state_nxt = S_RELEASE;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_RELEASE: begin
                if (idle) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = '0;
                end else if (cnt == TO_LAST) begin
                    state_nxt = S_DONE;
                    err_nxt   = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the state being entered so they register
    // alongside it.
    always_comb begin
        e_nxt    = 1'b0;
        w_nxt    = 1'b0;
        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state_nxt == S_DONE);
        case (state_nxt)
            S_PH1: begin
                e_nxt = ~dir_nxt;
                w_nxt = dir_nxt;
            end
            S_PH2: begin
                e_nxt = 1'b1;
                w_nxt = 1'b1;
            end
            S_PH3: begin
                e_nxt = dir_nxt;
                w_nxt = ~dir_nxt;
            end
            default: begin
                e_nxt = 1'b0;
                w_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            dir_q <= 1'b0;
            E     <= 1'b0;
            W     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dir_q <= dir_nxt;
            E     <= e_nxt;
            W     <= w_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_ew_sensor_driver.sv
// Directed bench for ew_sensor_driver: per-cycle {E,W,busy,done,err} vectors
// are queued by hand and compared one cycle at a time.
module tb_ew_sensor_driver;

    logic clk = 1'b0;
    logic rst, req, dir, idle;
    logic E, W, busy, done, err;
    logic idle_force, idle_val, det_y;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int d0;

    logic [4:0] exp_q[$];

    ew_sensor_driver #(.HOLD(4), .TIMEOUT(16), .CNT_W(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .dir  (dir),
        .idle (idle),
        .E    (E),
        .W    (W),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    always #5 clk = ~clk;

    // Stand-in detector: idle when both lines were low at the previous edge.
    always @(posedge clk or posedge rst) begin
        if (rst) det_y <= 1'b1;
        else     det_y <= ~E & ~W;
    end

    assign idle = idle_force ? idle_val : det_y;

    always @(negedge clk) begin
        if (!rst && done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_seg(input int n, input logic [4:0] v);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    task automatic drain(input string tag);
        int idx;
        logic [4:0] v;
        idx = 0;
        while (exp_q.size() > 0) begin
            step();
            v = exp_q.pop_front();
            check_eq($sformatf("%s[%0d]", tag, idx), {27'd0, E, W, busy, done, err}, {27'd0, v});
            idx++;
        end
    endtask

    // Vectors are {E, W, busy, done, err}
    localparam logic [4:0] V_IDLE = 5'b00000;
    localparam logic [4:0] V_WAIT = 5'b00100;
    localparam logic [4:0] V_E    = 5'b10100;
    localparam logic [4:0] V_EW   = 5'b11100;
    localparam logic [4:0] V_W    = 5'b01100;
    localparam logic [4:0] V_DONE = 5'b00110;
    localparam logic [4:0] V_DERR = 5'b00111;

    initial begin
        rst = 1'b1; req = 1'b0; dir = 1'b0;
        idle_force = 1'b0; idle_val = 1'b0;
        #12 rst = 1'b0;
        step();
        check_eq("reset_out", {27'd0, E, W, busy, done, err}, {27'd0, V_IDLE});

        // 1: async reset mid-PH2
        d0 = done_cnt;
        req = 1'b1; dir = 1'b0;
        push_seg(1, V_WAIT); push_seg(4, V_E); push_seg(1, V_EW);
        drain("t1_pre");
        req = 1'b0;
        #2 rst = 1'b1;
        #1 check_eq("t1_async_drop", {29'd0, E, W, busy}, 32'd0);
        #2 rst = 1'b0;
        push_seg(3, V_IDLE);
        drain("t1_post");
        check_eq("t1_no_done", done_cnt - d0, 32'd0);

        // 2: east-to-west with detector in loop
        d0 = done_cnt;
        req = 1'b1; dir = 1'b0;
        push_seg(1, V_WAIT);
        drain("t2_acc");
        req = 1'b0;
        push_seg(4, V_E); push_seg(4, V_EW); push_seg(4, V_W);
        push_seg(2, V_WAIT); push_seg(1, V_DONE); push_seg(1, V_IDLE);
        drain("t2");
        check_eq("t2_done_cnt", done_cnt - d0, 32'd1);

        // 3: west-to-east, dir toggled during PH2
        d0 = done_cnt;
        req = 1'b1; dir = 1'b1;
        push_seg(1, V_WAIT);
        drain("t3_acc");
        req = 1'b0;
        push_seg(4, V_W); push_seg(2, V_EW);
        drain("t3_a");
        dir = 1'b0;
        push_seg(2, V_EW); push_seg(4, V_E);
        push_seg(2, V_WAIT); push_seg(1, V_DONE); push_seg(1, V_IDLE);
        drain("t3_b");
        check_eq("t3_done_cnt", done_cnt - d0, 32'd1);

        // 4: release timeout with idle stuck low
        d0 = done_cnt;
        idle_force = 1'b1; idle_val = 1'b1;
        req = 1'b1; dir = 1'b0;
        push_seg(1, V_WAIT); push_seg(1, V_E);
        drain("t4_acc");
        req = 1'b0; idle_val = 1'b0;
        push_seg(3, V_E); push_seg(4, V_EW); push_seg(4, V_W);
        push_seg(16, V_WAIT); push_seg(1, V_DERR); push_seg(1, V_IDLE);
        drain("t4");
        check_eq("t4_done_cnt", done_cnt - d0, 32'd1);

        // 5a: not ready at request, idle rises after 5 WAIT_RDY cycles
        d0 = done_cnt;
        idle_val = 1'b0;
        req = 1'b1; dir = 1'b0;
        push_seg(1, V_WAIT);
        drain("t5a_acc");
        req = 1'b0;
        push_seg(4, V_WAIT);
        drain("t5a_wait");
        idle_val = 1'b1;
        push_seg(1, V_E);
        drain("t5a_ph1");
        idle_force = 1'b0;
        push_seg(3, V_E); push_seg(4, V_EW); push_seg(4, V_W);
        push_seg(2, V_WAIT); push_seg(1, V_DONE); push_seg(1, V_IDLE);
        drain("t5a");

        // 5b: idle never rises, WAIT_RDY times out with no sensor activity
        idle_force = 1'b1; idle_val = 1'b0;
        req = 1'b1;
        push_seg(1, V_WAIT);
        drain("t5b_acc");
        req = 1'b0;
        push_seg(15, V_WAIT); push_seg(1, V_DERR); push_seg(1, V_IDLE);
        drain("t5b");
        check_eq("t5_done_cnt", done_cnt - d0, 32'd2);

        // 6: req held high, back-to-back passages
        d0 = done_cnt;
        idle_force = 1'b0;
        req = 1'b1; dir = 1'b0;
        for (int p = 0; p < 2; p++) begin
            push_seg(1, V_WAIT); push_seg(4, V_E); push_seg(4, V_EW); push_seg(4, V_W);
            push_seg(2, V_WAIT); push_seg(1, V_DONE);
            if (p == 0) push_seg(1, V_IDLE);
        end
        drain("t6");
        req = 1'b0;
        push_seg(2, V_IDLE);
        drain("t6_end");
        check_eq("t6_done_cnt", done_cnt - d0, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
